write_ctrl_filt: RTL and testbench

//  Parametrised write-side control unit. Drives an external up-counter
//  (cnt_en) and writes selected counter values into the write port of an

---
 rtl/write_ctrl_filt.sv | 121 ++++++++++++
 tb/tb_write_ctrl_filt.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_ctrl_filt.sv
// Write-side controller: steps an external counter and writes values that pass
// a selectable filter into an async FIFO, with a write budget, abort and full-stall.
module write_ctrl_filt #(
    parameter int DW          = 16,
    parameter int CNT_W       = 16,
    parameter int STRIDE_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] max_writes,
    input  logic [DW-1:0]    data_in,
    input  logic             wfull,
    output logic             cnt_en,
    output logic             winc,
    output logic [DW-1:0]    wdata,
    output logic [CNT_W-1:0] wr_count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_WRITE = 3'd2,
        S_STALL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_wr_count;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_match;
    logic             w_last;
    logic             w_clr_cnt;
    logic             w_inc_cnt;

    assign wdata     = data_in;
    assign wr_count  = r_wr_count;
    assign w_cnt_inc = r_wr_count + 1'b1;
    assign w_last    = (max_writes != '0) && (w_cnt_inc == max_writes);

    always_comb begin
        w_match = 1'b0;
        unique case (mode)
            2'd0:    w_match = ^data_in;
            2'd1:    w_match = ~^data_in;
            2'd2:    w_match = 1'b1;
            default: w_match = (data_in[STRIDE_LOG2-1:0] == '0);
        endcase
    end

    // NOTE: every output and next-state signal gets a default before the case,
    // so no path through this block can infer a latch.
    always_comb begin
        w_next    = r_state;
        cnt_en    = 1'b0;
        winc      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        w_clr_cnt = 1'b0;
        w_inc_cnt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next    = S_RUN;
                    w_clr_cnt = 1'b1;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (!start)        w_next = S_IDLE;
                else if (wfull)    w_next = S_STALL;
                else if (w_match)  w_next = S_WRITE;  // hold counter so this value gets written
                else               cnt_en = 1'b1;
            end
            S_WRITE: begin
                busy = 1'b1;
                if (!start)       w_next = S_IDLE;
                else if (wfull)   w_next = S_STALL;
                else begin
                    winc      = 1'b1;
                    cnt_en    = 1'b1;
                    w_inc_cnt = 1'b1;
                    w_next    = w_last ? S_DONE : S_RUN;
                end
            end
            S_STALL: begin
                busy = 1'b1;
                if (!start)       w_next = S_IDLE;
                else if (!wfull)  w_next = S_RUN;
            end
            S_DONE: begin
                done = 1'b1;
                if (!start) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // Reset wins over a write or count step already decoded this cycle.
        if (rst) begin
            cnt_en = 1'b0;
            winc   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wr_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_clr_cnt)      r_wr_count <= '0;
            else if (w_inc_cnt) r_wr_count <= w_cnt_inc;
        end
    end

endmodule

// File: tb/tb_write_ctrl_filt.sv
// Self-checking bench for write_ctrl_filt: models the external counter and
// predicts the FIFO write sequence from the filter rules.
module tb_write_ctrl_filt;

    localparam int DW          = 8;
    localparam int CNT_W       = 4;
    localparam int STRIDE_LOG2 = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       mode;
    logic [CNT_W-1:0] max_writes;
    logic [DW-1:0]    data_in;
    logic             wfull;
    logic             cnt_en;
    logic             winc;
    logic [DW-1:0]    wdata;
    logic [CNT_W-1:0] wr_count;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    // External up-counter environment
    logic [DW-1:0] ext_cnt  = '0;
    logic          cnt_load = 1'b0;
    logic [DW-1:0] load_val = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cnt_load)    ext_cnt <= load_val;
        else if (cnt_en) ext_cnt <= ext_cnt + 1'b1;
    end

    assign data_in = ext_cnt;

    write_ctrl_filt #(
        .DW(DW), .CNT_W(CNT_W), .STRIDE_LOG2(STRIDE_LOG2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .max_writes(max_writes), .data_in(data_in), .wfull(wfull),
        .cnt_en(cnt_en), .winc(winc), .wdata(wdata), .wr_count(wr_count),
        .busy(busy), .done(done)
    );

    function automatic bit model_match(input int v, input int m);
        case (m)
            0:       return ($countones(v) % 2) == 1;
            1:       return ($countones(v) % 2) == 0;
            2:       return 1'b1;
            default: return (v % (1 << STRIDE_LOG2)) == 0;
        endcase
    endfunction

    task automatic load_counter(input logic [DW-1:0] v);
        @(negedge clk);
        cnt_load = 1'b1;
        load_val = v;
        @(negedge clk);
        cnt_load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; mode = 2'd0; max_writes = '0; wfull = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            checks++;
            if ({cnt_en, winc, busy, done} !== 4'b0 || wr_count !== '0) begin
                errors++;
                $display("FAIL reset cyc%0d: cnt_en/winc/busy/done=%b wr_count=%0d, want 0000/0",
                         i, {cnt_en, winc, busy, done}, wr_count);
            end
        end
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_release: busy=%b want 0 before edge", busy);
        end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL reset_to_run: busy=%b want 1 one cycle after rst", busy);
        end
        start = 1'b0;
        @(negedge clk); #1;
    endtask

    // Runs one budgeted session; expected writes are the first mw values from v0
    // that satisfy the filter, in order, regardless of wfull back-pressure.
    task automatic run_session(input logic [1:0] m, input logic [DW-1:0] v0,
                               input logic [CNT_W-1:0] mw, input int full_pct,
                               input string name);
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] got_q[$];
        logic [DW-1:0] v;
        int  cyc;
        bit  seen_done;
        v = v0;
        while (exp_q.size() < int'(mw)) begin
            if (model_match(int'(v), int'(m))) exp_q.push_back(v);
            v = v + 1'b1;
        end
        load_counter(v0);
        mode = m; max_writes = mw; start = 1'b1; wfull = 1'b0;
        cyc = 0; seen_done = 1'b0;
        while (!seen_done && cyc < 500) begin
            @(negedge clk);
            wfull = ($urandom_range(99) < full_pct);
            #1;
            if (wfull || busy) begin
                checks++;
                if ((wfull && winc) || (busy && done)) begin
                    errors++;
                    $display("FAIL %s_cycle: wfull=%b winc=%b busy=%b done=%b", name, wfull, winc, busy, done);
                end
            end
            if (winc) got_q.push_back(wdata);
            if (done) seen_done = 1'b1;
            cyc++;
        end
        checks++;
        if (!seen_done) begin
            errors++; $display("FAIL %s_timeout: done not seen in %0d cycles", name, cyc);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL %s_count: %0d writes, want %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_data[%0d]: got %0d want %0d", name, i,
                         (i < got_q.size()) ? int'(got_q[i]) : -1, exp_q[i]);
            end
        end
        checks++;
        if (wr_count !== mw || cnt_en !== 1'b0 || ext_cnt !== exp_q[$] + 1'b1) begin
            errors++;
            $display("FAIL %s_end: wr_count=%0d cnt_en=%b counter=%0d, want %0d/0/%0d",
                     name, wr_count, cnt_en, ext_cnt, mw, exp_q[$] + 1'b1);
        end
        wfull = 1'b0; start = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || wr_count !== mw) begin
            errors++;
            $display("FAIL %s_idle: busy=%b done=%b wr_count=%0d, want 0/0/%0d", name, busy, done, wr_count, mw);
        end
    endtask

    task automatic test_filters();
        run_session(2'd0, 8'd0, 4'd3, 0, "odd_parity");
        run_session(2'd1, 8'd0, 4'd3, 0, "even_parity");
    endtask

    task automatic test_stall();
        int n_w;
        logic [DW-1:0] w_val;
        bit seen_done;
        load_counter(8'd7);
        mode = 2'd2; max_writes = 4'd1; start = 1'b1; wfull = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b1 || cnt_en !== 1'b0 || winc !== 1'b0) begin
            errors++; $display("FAIL stall_run: busy=%b cnt_en=%b winc=%b want 1/0/0", busy, cnt_en, winc);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); wfull = 1'b1; #1;
            checks++;
            if (winc !== 1'b0 || cnt_en !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: winc=%b cnt_en=%b busy=%b want 0/0/1", i, winc, cnt_en, busy);
            end
        end
        n_w = 0; w_val = '0; seen_done = 1'b0;
        for (int i = 0; i < 8 && !seen_done; i++) begin
            @(negedge clk); wfull = 1'b0; #1;
            if (winc) begin n_w++; w_val = wdata; end
            if (done) seen_done = 1'b1;
        end
        checks++;
        if (n_w != 1 || w_val !== 8'd7 || !seen_done || ext_cnt !== 8'd8) begin
            errors++;
            $display("FAIL stall_release: writes=%0d value=%0d done=%b counter=%0d, want 1/7/1/8",
                     n_w, w_val, seen_done, ext_cnt);
        end
        start = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_abort();
        bit seen;
        load_counter(8'd3);
        mode = 2'd2; max_writes = '0; start = 1'b1; wfull = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); #1;
            if (winc) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL abort_first_write: no winc within 20 cycles"); end
        @(negedge clk); #1;
        @(negedge clk); start = 1'b0; #1;
        checks++;
        if (winc !== 1'b0 || cnt_en !== 1'b0) begin
            errors++; $display("FAIL abort_write: winc=%b cnt_en=%b want 0/0", winc, cnt_en);
        end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || wr_count !== 4'd1 || ext_cnt !== 8'd4) begin
            errors++;
            $display("FAIL abort_idle: busy=%b wr_count=%0d counter=%0d want 0/1/4", busy, wr_count, ext_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        load_counter(8'd5);
        mode = 2'd2; max_writes = '0; start = 1'b1; wfull = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); #1;
            if (winc) seen = 1'b1;
        end
        @(negedge clk); #1;
        @(negedge clk); rst = 1'b1; #1;
        checks++;
        if (!seen || winc !== 1'b0 || cnt_en !== 1'b0) begin
            errors++; $display("FAIL rst_mid_write: seen=%b winc=%b cnt_en=%b want 1/0/0", seen, winc, cnt_en);
        end
        @(negedge clk); rst = 1'b0; start = 1'b0; #1;
        checks++;
        if (busy !== 1'b0 || wr_count !== '0 || ext_cnt !== 8'd6) begin
            errors++;
            $display("FAIL rst_mid_idle: busy=%b wr_count=%0d counter=%0d want 0/0/6", busy, wr_count, ext_cnt);
        end
    endtask

    task automatic test_stride_wrap();
        int  n_w;
        bit  any_done;
        bit  chk16;
        load_counter(8'd0);
        mode = 2'd3; max_writes = '0; start = 1'b1; wfull = 1'b0;
        n_w = 0; any_done = 1'b0; chk16 = 1'b0;
        for (int i = 0; i < 300 && n_w < 17; i++) begin
            @(negedge clk); #1;
            if (done) any_done = 1'b1;
            if (n_w == 16 && !chk16) begin
                chk16 = 1'b1;
                checks++;
                if (wr_count !== 4'd0) begin
                    errors++; $display("FAIL stride_wrap: wr_count=%0d after 16 writes, want 0", wr_count);
                end
            end
            if (winc) begin
                checks++;
                if (wdata !== 8'(4 * n_w)) begin
                    errors++; $display("FAIL stride_data[%0d]: got %0d want %0d", n_w, wdata, 4 * n_w);
                end
                n_w++;
            end
        end
        @(negedge clk); #1;
        checks++;
        if (n_w != 17 || !chk16 || any_done || done !== 1'b0 || wr_count !== 4'd1) begin
            errors++;
            $display("FAIL stride_end: writes=%0d done_seen=%b wr_count=%0d want 17/0/1", n_w, any_done, wr_count);
        end
        start = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_random();
        for (int s = 0; s < 10; s++) begin
            run_session(2'($urandom_range(3)), 8'($urandom_range(255)),
                        4'($urandom_range(8, 1)), 25, $sformatf("rand%0d", s));
        end
    endtask

    initial begin
        test_reset();
        test_filters();
        test_stall();
        test_abort();
        test_reset_mid();
        test_stride_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
